// File: rtl/alu_exec_pkg.sv
// Shared encodings for the execute-stage ALU/MDU.
// Holds alu_op codes, the internal op enum, funct7 values and FSM states.
package alu_exec_pkg;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MDU  = 7'b0000001;

  // Bit 4 set marks the M-extension ops; low bits mirror funct3.
  typedef enum logic [4:0] {
    OP_AND    = 5'b00000,
    OP_OR     = 5'b00001,
    OP_ADD    = 5'b00010,
    OP_XOR    = 5'b00011,
    OP_SUB    = 5'b00110,
    OP_SLT    = 5'b00111,
    OP_SLTU   = 5'b01000,
    OP_SLL    = 5'b01001,
    OP_SRL    = 5'b01010,
    OP_SRA    = 5'b01011,
    OP_MUL    = 5'b10000,
    OP_MULH   = 5'b10001,
    OP_MULHSU = 5'b10010,
    OP_MULHU  = 5'b10011,
    OP_DIV    = 5'b10100,
    OP_DIVU   = 5'b10101,
    OP_REM    = 5'b10110,
    OP_REMU   = 5'b10111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_e;

  function automatic op_e f3_op(
    input logic [2:0] f3,
    input logic       alt
  );
    op_e o;
    o = OP_ADD;
    case (f3)
      3'b000: o = alt ? OP_SUB : OP_ADD;
      3'b001: o = OP_SLL;
      3'b010: o = OP_SLT;
      3'b011: o = OP_SLTU;
      3'b100: o = OP_XOR;
      3'b101: o = alt ? OP_SRA : OP_SRL;
      3'b110: o = OP_OR;
      3'b111: o = OP_AND;
      default: o = OP_ADD;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/alu_exec_unit_decode.sv
// Combinational funct3/funct7 decoder for the execute unit.
// Produces the internal op code and an illegal flag.
module alu_exec_decode
  import alu_exec_pkg::*;
#(
  parameter bit EN_MDU = 1'b1
) (
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output op_e        op,
  output logic       illegal
);

  logic f3_alt_ok;
  logic f3_sr;
  logic f3_sl;

  assign f3_sr     = funct3 == 3'b101;
  assign f3_sl     = funct3 == 3'b001;
  assign f3_alt_ok = (funct3 == 3'b000) || f3_sr;

  always_comb begin
    op      = OP_ADD;
    illegal = 1'b0;
    unique case (1'b1)
      alu_op == ALUOP_MEM: op = OP_ADD;
      alu_op == ALUOP_BR:  op = OP_SUB;
      alu_op == ALUOP_R: begin
        unique case (1'b1)
          funct7 == F7_BASE:
            op = f3_op(funct3, 1'b0);
          funct7 == F7_ALT && f3_alt_ok:
            op = f3_op(funct3, 1'b1);
          funct7 == F7_MDU && EN_MDU:
            op = op_e'({2'b10, funct3});
          default:
            illegal = 1'b1;
        endcase
      end
      default: begin
        // I-type: funct7 is immediate except for shifts.
        op = f3_op(funct3, f3_sr && funct7 == F7_ALT);
        if (f3_sr && funct7 != F7_BASE
            && funct7 != F7_ALT)
          illegal = 1'b1;
        if (f3_sl && funct7 != F7_BASE)
          illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with iterative multiply/divide.
// Base ops finish in one cycle; MDU ops take XLEN iterations.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit EN_MDU = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN =
    {1'b1, {(XLEN-1){1'b0}}};

  op_e    op;
  op_e    op_q;
  state_e state;
  logic   dec_illegal;

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hi, lo, dvs;
  logic [XLEN-1:0] hi_n, lo_n;
  logic            a_neg, b_neg;

  alu_exec_decode #(.EN_MDU(EN_MDU)) u_decode (
    .alu_op  (alu_op),
    .funct3  (funct3),
    .funct7  (funct7),
    .op      (op),
    .illegal (dec_illegal)
  );

  logic accept;
  assign in_ready = (state == S_IDLE)
                 && (!out_valid || out_ready)
                 && !flush;
  assign accept = in_valid && in_ready;

  logic [CW-1:0]   shamt;
  logic [XLEN-1:0] base_res;
  assign shamt = op_b[CW-1:0];

  always_comb begin
    base_res = '0;
    case (op)
      OP_AND:  base_res = op_a & op_b;
      OP_OR:   base_res = op_a | op_b;
      OP_ADD:  base_res = op_a + op_b;
      OP_XOR:  base_res = op_a ^ op_b;
      OP_SUB:  base_res = op_a - op_b;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}},
        $signed(op_a) < $signed(op_b)};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}},
        op_a < op_b};
      OP_SLL:  base_res = op_a << shamt;
      OP_SRL:  base_res = op_a >> shamt;
      OP_SRA:  base_res =
        $unsigned($signed(op_a) >>> shamt);
      default: base_res = '0;
    endcase
  end

  logic is_div, is_q, b_zero, ovf, fast, slow;
  logic sa_neg, sb_neg;
  logic [XLEN-1:0] fast_res, imm_res;
  logic [XLEN-1:0] a_mag, b_mag;

  assign is_div = op inside
    {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign is_q   = op inside {OP_DIV, OP_DIVU};
  assign b_zero = op_b == '0;
  assign ovf    = (op inside {OP_DIV, OP_REM})
               && op_a == SMIN && &op_b;
  assign fast   = is_div && (b_zero || ovf);
  assign slow   = !dec_illegal && op[4] && !fast;

  always_comb begin
    if (b_zero)
      fast_res = is_q ? '1 : op_a;
    else
      fast_res = (op == OP_DIV) ? op_a : '0;
  end

  assign imm_res = dec_illegal ? '0
                 : fast ? fast_res : base_res;

  assign sa_neg = op_a[XLEN-1] && (op inside
    {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign sb_neg = op_b[XLEN-1] && (op inside
    {OP_MUL, OP_MULH, OP_DIV, OP_REM});
  assign a_mag = sa_neg ? -op_a : op_a;
  assign b_mag = sb_neg ? -op_b : op_b;

  // One shift-add or restore step on {hi, lo}.
  logic [XLEN:0] sum, shl, diff;
  assign sum  = {1'b0, hi} + {1'b0, dvs};
  assign shl  = {hi, lo[XLEN-1]};
  assign diff = shl - {1'b0, dvs};

  always_comb begin
    if (state == S_DIV) begin
      hi_n = diff[XLEN] ? shl[XLEN-1:0]
                        : diff[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], ~diff[XLEN]};
    end else begin
      {hi_n, lo_n} = {(lo[0] ? sum : {1'b0, hi}),
                      lo[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod, prod_f;
  logic [XLEN-1:0]   q_f, r_f, mdu_res;

  assign prod   = {hi_n, lo_n};
  assign prod_f = (a_neg ^ b_neg) ? -prod : prod;
  assign q_f    = (a_neg ^ b_neg) ? -lo_n : lo_n;
  assign r_f    = a_neg ? -hi_n : hi_n;

  always_comb begin
    case (op_q)
      OP_MUL:  mdu_res = prod_f[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:
               mdu_res = prod_f[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:
               mdu_res = q_f;
      default: mdu_res = r_f;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      op_q      <= OP_ADD;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      dvs       <= '0;
    end else if (flush) begin
      state     <= S_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept && slow) begin
            state <= op[2] ? S_DIV : S_MUL;
            busy  <= 1'b1;
            cnt   <= '0;
            op_q  <= op;
            a_neg <= sa_neg;
            b_neg <= sb_neg;
            hi    <= '0;
            lo    <= a_mag;
            dvs   <= b_mag;
          end else if (accept) begin
            out_valid <= 1'b1;
            result    <= imm_res;
            zero      <= imm_res == '0;
            illegal   <= dec_illegal;
          end
        end
        default: begin
          hi  <= hi_n;
          lo  <= lo_n;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b1;
            result    <= mdu_res;
            zero      <= mdu_res == '0;
            illegal   <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus random
// traffic compared against an arithmetic reference model.
module tb_alu_exec_unit;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [1:0]  alu_op = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        in_ready, out_valid, zero, illegal, busy;
  logic [31:0] result;

  alu_exec_unit #(.XLEN(XLEN), .EN_MDU(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7    (funct7),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] r;
    logic        ill;
    int          due;
    bit          slow;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
  endtask

  function automatic logic [31:0] base_op(input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f3)
      3'd0: return a + b;
      3'd1: return a << b[4:0];
      3'd2: return (sa < sb) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Reference: plain 64-bit arithmetic on the RISC-V rules.
  function automatic void model(input logic [1:0] aop,
    input logic [2:0] f3, input logic [6:0] f7,
    input logic [31:0] a, input logic [31:0] b,
    output logic [31:0] r, output logic ill, output bit slow);
    longint sa, sb;
    logic [63:0] p, ua, ub, sra_v;
    bit ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    sra_v = sa >>> b[4:0];
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = '0;
    ill = 1'b0;
    slow = 1'b0;
    case (aop)
      2'd0: r = a + b;
      2'd1: r = a - b;
      2'd2: begin
        if (f7 == 7'h01) begin
          case (f3)
            3'd0: begin p = sa * sb; r = p[31:0]; slow = 1; end
            3'd1: begin p = sa * sb; r = p[63:32]; slow = 1; end
            3'd2: begin
              p = sa * longint'(ub); r = p[63:32]; slow = 1;
            end
            3'd3: begin p = ua * ub; r = p[63:32]; slow = 1; end
            3'd4:
              if (b == 0) r = '1;
              else if (ovf) r = a;
              else begin r = 32'(sa / sb); slow = 1; end
            3'd5:
              if (b == 0) r = '1;
              else begin r = a / b; slow = 1; end
            3'd6:
              if (b == 0) r = a;
              else if (ovf) r = '0;
              else begin r = 32'(sa % sb); slow = 1; end
            default:
              if (b == 0) r = a;
              else begin r = a % b; slow = 1; end
          endcase
        end else if (f7 == 7'h20) begin
          if (f3 == 3'd0) r = a - b;
          else if (f3 == 3'd5) r = sra_v[31:0];
          else ill = 1'b1;
        end else if (f7 == 7'h00) begin
          r = base_op(f3, a, b);
        end else begin
          ill = 1'b1;
        end
      end
      default: begin
        if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
        else if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)
          ill = 1'b1;
        else if (f3 == 3'd5 && f7 == 7'h20) r = sra_v[31:0];
        else r = base_op(f3, a, b);
      end
    endcase
    if (ill) r = '0;
  endfunction

  // Compare process: checks handshake and outputs every cycle.
  task automatic monitor();
    bit   have, ov_e, ir_e, bz_e, sl;
    exp_t f, e;
    logic [31:0] r;
    logic ill;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
      end else begin
        have = q.size() > 0;
        if (have) f = q[0];
        ov_e = have && (cyc >= f.due);
        bz_e = have && (cyc < f.due) && f.slow;
        ir_e = !flush && (!have || (ov_e && out_ready));
        chk("in_ready", in_ready, ir_e);
        chk("out_valid", out_valid, ov_e);
        chk("busy", busy, bz_e);
        if (ov_e && out_valid) begin
          chk("result", result, f.r);
          chk("zero", zero, f.r == 0);
          chk("illegal", illegal, f.ill);
        end
        if (flush) begin
          q.delete();
        end else begin
          if (ov_e && out_ready) void'(q.pop_front());
          if (in_valid && ir_e) begin
            model(alu_op, funct3, funct7, op_a, op_b, r, ill, sl);
            e.r = r;
            e.ill = ill;
            e.slow = sl;
            e.due = cyc + (sl ? XLEN + 1 : 1);
            q.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic send(input logic [1:0] aop, input logic [2:0] f3,
    input logic [6:0] f7, input logic [31:0] a,
    input logic [31:0] b, output int acc);
    @(posedge clk);
    #1;
    alu_op = aop; funct3 = f3; funct7 = f7;
    op_a = a; op_b = b; in_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) timeout("send");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string nm, input int acc,
    input int lat, input logic [31:0] r_exp,
    input logic ill_exp, output int nb);
    bit got;
    got = 0;
    nb = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1;
        break;
      end
      if (busy && !in_ready) nb++;
    end
    if (!got) begin
      timeout(nm);
    end else begin
      chk({nm, "_lat"}, cyc - acc, lat);
      chk({nm, "_res"}, result, r_exp);
      chk({nm, "_zero"}, zero, r_exp == 0);
      chk({nm, "_ill"}, illegal, ill_exp);
    end
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [6:0] rnd_f7();
    case ($urandom_range(0, 7))
      0, 1, 2: return 7'h00;
      3, 7:    return 7'h20;
      4, 5:    return 7'h01;
      default: return 7'($urandom);
    endcase
  endfunction

  initial begin
    int acc, nb, cnt_ov;
    logic [31:0] mr;
    logic mi;
    bit ms;

    fork
      monitor();
    join_none

    model(2'd2, 3'd0, 7'h00, 32'd5, 32'd7, mr, mi, ms);
    chk("model_add", mr, 32'd12);
    model(2'd2, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          mr, mi, ms);
    chk("model_mulhu", mr, 32'hFFFF_FFFE);
    model(2'd2, 3'd2, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          mr, mi, ms);
    chk("model_mulhsu", mr, 32'hFFFF_FFFF);
    model(2'd3, 3'd2, 7'h7F, 32'hFFFF_FFFF, 32'd1, mr, mi, ms);
    chk("model_slti", mr, 32'd1);
    model(2'd2, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1, mr, mi, ms);
    chk("model_sltu", mr, 32'd0);
    model(2'd2, 3'd7, 7'h01, 32'hFFFF_FFF9, 32'd2, mr, mi, ms);
    chk("model_remu", mr, 32'd1);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);

    send(2'd2, 3'd0, 7'h00, 32'd5, 32'd7, acc);
    wait_out("add", acc, 1, 32'd12, 1'b0, nb);
    send(2'd2, 3'd0, 7'h20, 32'd9, 32'd9, acc);
    wait_out("sub", acc, 1, 32'd0, 1'b0, nb);
    send(2'd3, 3'd5, 7'h20, 32'h8000_0000, 32'h24, acc);
    wait_out("srai", acc, 1, 32'hF800_0000, 1'b0, nb);
    send(2'd3, 3'd5, 7'h01, 32'h8000_0000, 32'h24, acc);
    wait_out("srai_bad", acc, 1, 32'd0, 1'b1, nb);

    send(2'd2, 3'd1, 7'h01, 32'hFFFF_FFFE, 32'd3, acc);
    wait_out("mulh", acc, 33, 32'hFFFF_FFFF, 1'b0, nb);
    chk("mulh_busy_cycles", nb, 32);
    send(2'd2, 3'd4, 7'h01, 32'hFFFF_FFF9, 32'd2, acc);
    wait_out("div", acc, 33, 32'hFFFF_FFFD, 1'b0, nb);
    send(2'd2, 3'd6, 7'h01, 32'hFFFF_FFF9, 32'd2, acc);
    wait_out("rem", acc, 33, 32'hFFFF_FFFF, 1'b0, nb);

    send(2'd2, 3'd5, 7'h01, 32'd10, 32'd0, acc);
    wait_out("divu_z", acc, 1, 32'hFFFF_FFFF, 1'b0, nb);
    send(2'd2, 3'd6, 7'h01, 32'd10, 32'd0, acc);
    wait_out("rem_z", acc, 1, 32'd10, 1'b0, nb);
    send(2'd2, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, acc);
    wait_out("div_ovf", acc, 1, 32'h8000_0000, 1'b0, nb);

    // Backpressure then same-cycle consume/accept.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(2'd0, 3'd0, 7'h00, 32'd1, 32'd2, acc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", result, 32'd3);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    alu_op = 2'd0; op_a = 32'd4; op_b = 32'd4;
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp_swap_ready", in_ready, 1'b1);
    acc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_new_valid", out_valid, 1'b1);
    chk("bp_new_res", result, 32'd8);
    chk("bp_new_lat", cyc - acc, 1);

    // Flush in the 10th cycle of a divide.
    send(2'd2, 3'd4, 7'h01, 32'd100, 32'd7, acc);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_cycle", cyc - acc, 10);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_out_valid", out_valid, 1'b0);
    cnt_ov = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) cnt_ov++;
    end
    chk("flush_no_out", cnt_ov, 0);

    // Async reset in the middle of a multiply.
    send(2'd0, 3'd0, 7'h00, 32'd20, 32'd22, acc);
    wait_out("pre_rst", acc, 1, 32'd42, 1'b0, nb);
    send(2'd2, 3'd0, 7'h01, 32'd6, 32'd7, acc);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_result", result, 32'd0);
    chk("mrst_zero", zero, 1'b0);
    chk("mrst_illegal", illegal, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (40) @(posedge clk);

    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      in_valid  = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 8;
      flush     = $urandom_range(0, 63) == 0;
      alu_op    = 2'($urandom_range(0, 3));
      funct3    = 3'($urandom_range(0, 7));
      funct7    = rnd_f7();
      op_a      = rnd_op();
      op_b      = rnd_op();
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
